// File: rtl/mem_arbiter_if.sv
// Requester and memory signal bundle for mem_arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic [2:0]        req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W-1:0] store_addr;
    logic [DATA_W-1:0] store_data;
    logic [2:0]        gnt;
    logic [2:0]        done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req, fetch_addr, load_addr, store_addr, store_data, mem_rdata, mem_ack,
        output gnt, done, rdata, err, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, fetch_addr, load_addr, store_addr, store_data, mem_rdata, mem_ack,
        input  gnt, done, rdata, err, busy, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-requester (fetch/load/store) arbiter for a single memory port with BUSY timeout.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority store > load > fetch.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [1:0]        r_owner;
    logic [7:0]        r_cnt;
    logic [2:0]        r_gnt;
    logic [2:0]        r_done;
    logic              r_err;
    logic              r_busy;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        w_win;
    logic [ADDR_W-1:0] w_addr;
`ifdef ARB_RR_EN
    logic [1:0]        r_ptr;
`endif

    // Winner select; only consumed when at least one req bit is set.
    always_comb begin
        w_win = 2'd0;
`ifdef ARB_RR_EN
        case (r_ptr)
            2'd0:    w_win = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
            2'd1:    w_win = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
            default: w_win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
        endcase
`else
        w_win = bus.req[2] ? 2'd2 : (bus.req[1] ? 2'd1 : 2'd0);
`endif
    end

    always_comb begin
        w_addr = bus.fetch_addr;
        case (w_win)
            2'd1:    w_addr = bus.load_addr;
            2'd2:    w_addr = bus.store_addr;
            default: w_addr = bus.fetch_addr;
        endcase
    end

    // Control FSM; gnt/done default low so they pulse for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 2'd0;
            r_cnt       <= 8'd0;
            r_gnt       <= 3'b000;
            r_done      <= 3'b000;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
`ifdef ARB_RR_EN
            r_ptr       <= 2'd2;
`endif
        end else begin
            r_gnt  <= 3'b000;
            r_done <= 3'b000;
            case (r_state)
                S_IDLE: begin
                    if (bus.req != 3'b000) begin
                        r_state    <= S_BUSY;
                        r_busy     <= 1'b1;
                        r_owner    <= w_win;
                        r_gnt      <= 3'b001 << w_win;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= (w_win == 2'd2);
                        r_mem_addr <= w_addr;
                        r_cnt      <= 8'd0;
                        if (w_win == 2'd2) r_mem_wdata <= bus.store_data;
`ifdef ARB_RR_EN
                        r_ptr      <= w_win;
`endif
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ack) begin
                        r_state   <= S_RESP;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 3'b001 << r_owner;
                        r_err     <= 1'b0;
                        if (r_owner != 2'd2) r_rdata <= bus.mem_rdata;
                    end else if (r_cnt == CNT_LAST) begin
                        // Memory never answered: abort with error and zeroed read data.
                        r_state   <= S_RESP;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 3'b001 << r_owner;
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of requester and memory ports.
REQ-002 Parameter: DATA_W, 64, data width of load/store data and read data.
REQ-003 Parameter: TIMEOUT, 15, maximum BUSY cycles without mem_ack before abort (range 1..255).
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-006 req  in  3  request per requester: bit0 fetch, bit1 load, bit2 store.
REQ-007 fetch_addr, load_addr, store_addr  in  ADDR_W each  byte address per requester.
REQ-008 store_data  in  DATA_W  write data for the store requester.
REQ-009 gnt  out  3  one-hot grant pulse, registered.
REQ-010 done  out  3  one-hot completion pulse, registered.
REQ-011 rdata  out  DATA_W  read data, valid while done[0] or done[1] is high.
REQ-012 err  out  1  timeout flag, valid while done is nonzero.
REQ-013 busy  out  1  high when state is not IDLE.
REQ-014 mem_req, mem_we  out  1 each  memory request and write enable.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  memory address and write data, registered.
REQ-016 mem_rdata  in  DATA_W; mem_ack  in  1  memory read data and completion.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-018 IDLE with req != 0: on the edge, the block SHALL select one winner, latch its address (and store_data if the winner is the store requester), pulse gnt[winner] for one cycle, drive mem_req=1 with mem_we=(winner==2), and enter BUSY.
REQ-019 IDLE with req == 0: the block SHALL stay in IDLE with mem_req=0.
REQ-020 BUSY: mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until the edge on which mem_ack=1 is sampled.
REQ-021 BUSY with mem_ack=1: the block SHALL drop mem_req, enter RESP, pulse done[owner] for one cycle with err=0, and latch rdata=mem_rdata for reads; rdata SHALL stay unchanged for stores.
REQ-022 RESP: the block SHALL perform no arbitration and SHALL enter IDLE on the next edge.
REQ-023 Requesters SHALL hold req until their done pulse and deassert it by the edge that ends RESP; a req high in IDLE is always a new request.
REQ-024 Deasserting req after a grant SHALL NOT cancel the transaction.
REQ-025 Latency: with mem_ack in the first BUSY cycle, done SHALL be high 2 cycles after req is sampled in IDLE; back-to-back transactions SHALL take at least 3 cycles each.
REQ-026 An 8-bit counter SHALL count BUSY cycles; if mem_ack has not been seen by the end of the TIMEOUT-th BUSY cycle, the block SHALL drop mem_req, enter RESP with done[owner]=1, err=1 and rdata=0.
REQ-027 mem_ack=1 on the TIMEOUT-th edge SHALL complete normally with err=0.
REQ-028 mem_ack while in IDLE or RESP SHALL be ignored.
REQ-029 gnt and done SHALL never both be nonzero in the same cycle; each SHALL be at most one-hot.

Reset
REQ-030 While reset=0: state=IDLE; gnt, done, err, busy, mem_req and mem_we = 0; mem_addr, mem_wdata, rdata and the counter = 0; the round-robin pointer = 2.
REQ-031 Reset asserted mid-transaction SHALL drop the transaction with no done pulse; the memory SHALL see mem_req fall asynchronously.

Configuration
REQ-032 Macro ARB_RR_EN defined: round-robin arbitration; search order starts at the index after the last winner (pointer updated on every grant), so fetch wins first after reset.
REQ-033 Macro ARB_RR_EN undefined: fixed priority store(2) > load(1) > fetch(0); the pointer register SHALL NOT exist.

Verification
REQ-034 req=3'b001, fetch_addr=0x2000, mem_ack one cycle after mem_req, mem_rdata=0xDEAD -> gnt=001 in cycle 1; done=001, rdata=0xDEAD, err=0 in cycle 2.
REQ-035 req=3'b100, store_addr=0x100, store_data=0x1122334455667788 -> mem_we=1, mem_addr=0x100, mem_wdata=0x1122334455667788 held stable until mem_ack; then done=100 and rdata unchanged.
REQ-036 req=3'b111 held for 3 transactions: without ARB_RR_EN grants are 100, 100, 100; with ARB_RR_EN grants are 001, 010, 100.
REQ-037 TIMEOUT=4, mem_ack never asserted -> mem_req high for exactly 4 cycles; then done=owner, err=1, rdata=0; back in IDLE 1 cycle later.
REQ-038 reset pulled low during BUSY -> mem_req=0 immediately with no done pulse; after release, req=010 is granted normally.
